// File: rtl/bin_to_dis.sv
// Sequential 20-bit binary to six-digit BCD converter (shift-add-3) feeding the
// seven-segment scanner; digit outputs only change on the cycle a result is ready.
module bin_to_dis #(
  parameter int BIN_W   = 20,
  parameter int MAX_VAL = 999999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       dis1,
  output logic [3:0]       dis2,
  output logic [3:0]       dis3,
  output logic [3:0]       dis4,
  output logic [3:0]       dis5,
  output logic [3:0]       dis6
);

  localparam logic [BIN_W-1:0] MAX_V     = BIN_W'(MAX_VAL);
  localparam logic [4:0]       ITER_LAST = 5'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [BIN_W-1:0] v;
  logic [23:0]      bcd;
  logic [23:0]      bcd_adj;
  logic [4:0]       iter;
  logic             too_big;

  // Correct every nibble that would overflow past 9 once doubled.
  function automatic logic [23:0] add3_all(input logic [23:0] b);
    logic [23:0] r;
    r = b;
    for (int i = 0; i < 6; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and datapath helpers
  always_comb begin
    next_state = state;
    bcd_adj    = add3_all(bcd);
    too_big    = (bin_in > MAX_V);
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
      SHIFT: begin
        if (iter == ITER_LAST) begin
          next_state = DONE;
        end else begin
          next_state = SHIFT;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Conversion datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      v    <= '0;
      bcd  <= 24'd0;
      iter <= 5'd0;
      busy <= 1'b0;
      done <= 1'b0;
      ovf  <= 1'b0;
      dis1 <= 4'd0;
      dis2 <= 4'd0;
      dis3 <= 4'd0;
      dis4 <= 4'd0;
      dis5 <= 4'd0;
      dis6 <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            v    <= too_big ? MAX_V : bin_in;
            ovf  <= too_big;
            bcd  <= 24'd0;
            iter <= 5'd0;
            busy <= 1'b1;
          end
        end
        SHIFT: begin
          bcd  <= {bcd_adj[22:0], v[BIN_W-1]};
          v    <= {v[BIN_W-2:0], 1'b0};
          iter <= iter + 5'd1;
        end
        DONE: begin
          // Digits move only here so the display never shows a partial result.
          dis1 <= bcd[23:20];
          dis2 <= bcd[19:16];
          dis3 <= bcd[15:12];
          dis4 <= bcd[11:8];
          dis5 <= bcd[7:4];
          dis6 <= bcd[3:0];
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_dis.sv
// Self-checking bench for bin_to_dis: expected digits come from a decimal
// arithmetic model, queued at start and compared when done pulses.
module tb_bin_to_dis;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] bin_in;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  dis1, dis2, dis3, dis4, dis5, dis6;

  int checks = 0;
  int errors = 0;
  logic [24:0] sb[$];

  bin_to_dis dut (
    .clk(clk), .rst(rst), .bin_in(bin_in), .start(start),
    .busy(busy), .done(done), .ovf(ovf),
    .dis1(dis1), .dis2(dis2), .dis3(dis3), .dis4(dis4), .dis5(dis5), .dis6(dis6)
  );

  always #5 clk = ~clk;

  // {ovf, d1..d6} computed by saturating and peeling off decimal digits.
  function automatic logic [24:0] model(input int unsigned val);
    int unsigned s;
    logic [24:0] r;
    s = (val > 999999) ? 999999 : val;
    r[24] = (val > 999999);
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return r;
  endfunction

  task automatic do_start(input int unsigned val);
    @(negedge clk);
    bin_in = 20'(val);
    start  = 1'b1;
    sb.push_back(model(val));
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) bcnt++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; bin_in = 20'd123456;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, ovf, dis1, dis2, dis3, dis4, dis5, dis6} !== 27'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b ovf=%b dis=%h, required all 0",
               busy, done, ovf, {dis1, dis2, dis3, dis4, dis5, dis6});
    end
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_start: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, bcnt;
    logic [24:0] exp;
    do_start(123456);
    wait_done(lat, bcnt);
    checks++;
    if (lat !== 21) begin
      errors++; $display("FAIL basic_latency: got %0d cycles, required 21", lat);
    end
    checks++;
    if (bcnt !== 21) begin
      errors++; $display("FAIL basic_busy_len: got %0d cycles, required 21", bcnt);
    end
    exp = sb.pop_front();
    checks++;
    if ({ovf, dis1, dis2, dis3, dis4, dis5, dis6} !== exp) begin
      errors++;
      $display("FAIL basic_result: got ovf=%b dis=%h, required ovf=%b dis=%h",
               ovf, {dis1, dis2, dis3, dis4, dis5, dis6}, exp[24], exp[23:0]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_zero_max();
    int lat, bcnt;
    logic [24:0] exp;
    logic [24:0] vals[2] = '{25'd0, 25'd999999};
    for (int k = 0; k < 2; k++) begin
      do_start(int'(vals[k]));
      if (k == 1) begin
        repeat (10) @(negedge clk);
        checks++;
        if ({busy, dis1, dis2, dis3, dis4, dis5, dis6} !== {1'b1, 24'h000000}) begin
          errors++;
          $display("FAIL hold_mid_conv: busy=%b dis=%h, required 1 000000",
                   busy, {dis1, dis2, dis3, dis4, dis5, dis6});
        end
      end
      wait_done(lat, bcnt);
      exp = sb.pop_front();
      checks++;
      if ({ovf, dis1, dis2, dis3, dis4, dis5, dis6} !== exp) begin
        errors++;
        $display("FAIL zero_max_result[%0d]: got ovf=%b dis=%h, required ovf=%b dis=%h",
                 k, ovf, {dis1, dis2, dis3, dis4, dis5, dis6}, exp[24], exp[23:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ovf();
    int lat, bcnt;
    logic [24:0] exp;
    int unsigned vals[3] = '{1000000, 20'hFFFFF, 42};
    for (int k = 0; k < 3; k++) begin
      do_start(vals[k]);
      wait_done(lat, bcnt);
      exp = sb.pop_front();
      checks++;
      if ({ovf, dis1, dis2, dis3, dis4, dis5, dis6} !== exp) begin
        errors++;
        $display("FAIL ovf_result[%0d]: got ovf=%b dis=%h, required ovf=%b dis=%h",
                 k, ovf, {dis1, dis2, dis3, dis4, dis5, dis6}, exp[24], exp[23:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bcnt, extra;
    logic [24:0] exp;
    do_start(500000);
    repeat (5) @(negedge clk);
    bin_in = 20'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    exp = sb.pop_front();
    checks++;
    if ({ovf, dis1, dis2, dis3, dis4, dis5, dis6} !== exp) begin
      errors++;
      $display("FAIL ignore_result: got ovf=%b dis=%h, required ovf=%b dis=%h",
               ovf, {dis1, dis2, dis3, dis4, dis5, dis6}, exp[24], exp[23:0]);
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL ignore_second_start: %0d busy/done cycles after result, required 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bcnt, extra;
    logic [24:0] exp;
    do_start(123456);
    wait_done(lat, bcnt);
    void'(sb.pop_front());
    @(negedge clk);
    bin_in = 20'd654321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, ovf, dis1, dis2, dis3, dis4, dis5, dis6} !== 27'd0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b ovf=%b dis=%h, required all 0",
               busy, done, ovf, {dis1, dis2, dis3, dis4, dis5, dis6});
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL abort_no_done: %0d done pulses after reset, required 0", extra);
    end
    do_start(654321);
    wait_done(lat, bcnt);
    exp = sb.pop_front();
    checks++;
    if ({lat[5:0], ovf, dis1, dis2, dis3, dis4, dis5, dis6} !== {6'd21, exp}) begin
      errors++;
      $display("FAIL abort_fresh: got lat=%0d ovf=%b dis=%h, required lat=21 ovf=%b dis=%h",
               lat, ovf, {dis1, dis2, dis3, dis4, dis5, dis6}, exp[24], exp[23:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic [24:0] exp;
    @(negedge clk);
    bin_in = 20'd111111; start = 1'b1;
    sb.push_back(model(111111));
    @(negedge clk);
    bin_in = 20'd222222;
    sb.push_back(model(222222));
    for (int k = 0; k < 2; k++) begin
      if (k == 1) @(negedge clk);
      wait_done(lat, bcnt);
      if (k == 1) start = 1'b0;
      exp = sb.pop_front();
      checks++;
      if ({lat[5:0], ovf, dis1, dis2, dis3, dis4, dis5, dis6} !== {6'd21, exp}) begin
        errors++;
        $display("FAIL b2b_result[%0d]: got lat=%0d ovf=%b dis=%h, required lat=21 ovf=%b dis=%h",
                 k, lat, ovf, {dis1, dis2, dis3, dis4, dis5, dis6}, exp[24], exp[23:0]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_stop: busy=%b after start dropped, required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_max();
    test_ovf();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL scoreboard_empty: %0d results never produced, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
